// File: rtl/dvs_ravens_pkg.sv
// rtl/dvs_ravens_pkg.sv - shared constants and event types for the DVS to RAVENS path
package dvs_ravens_pkg;

   localparam int CLK_PERIOD_NS    = 10;
   // Kept for older users; it truncates to 0 and must not drive tick generation.
   localparam int CLK_PERIOD_US    = CLK_PERIOD_NS / 1000;
   localparam int CYCLES_PER_US    = 1000 / CLK_PERIOD_NS;

   localparam int DVS_X_ADDR_BITS  = 9;
   localparam int DVS_Y_ADDR_BITS  = 9;
   localparam int TIMESTAMP_BITS   = 48;
   localparam int DVS_SENSOR_WIDTH = 346;
   localparam int DVS_SENSOR_HEIGHT = 260;

   typedef struct packed {
      logic [DVS_X_ADDR_BITS-1:0] x;
      logic [DVS_Y_ADDR_BITS-1:0] y;
      logic                       pol;
   } dvs_event_t;

   typedef struct packed {
      dvs_event_t                evt;
      logic [TIMESTAMP_BITS-1:0] ts;
   } ts_event_t;

   function automatic logic in_sensor(input logic [DVS_X_ADDR_BITS-1:0] x,
                                      input logic [DVS_Y_ADDR_BITS-1:0] y);
      return (32'(x) < DVS_SENSOR_WIDTH) && (32'(y) < DVS_SENSOR_HEIGHT);
   endfunction

endpackage

// File: rtl/dvs_event_fifo.sv
// rtl/dvs_event_fifo.sv - synchronous FIFO of timestamped events, head read from registers
module dvs_event_fifo
   import dvs_ravens_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  ts_event_t wdata,
   output logic      full,
   input  logic      pop,
   output logic      empty,
   output ts_event_t rdata
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0] wptr_q, wptr_d;
   logic [AW:0] rptr_q, rptr_d;
   ts_event_t   mem_q [DEPTH];

   // Extra MSB on each pointer distinguishes full from empty when the indices match.
   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign rdata = mem_q[rptr_q[AW-1:0]];

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push) wptr_d = wptr_q + PTR_ONE;
      if (pop)  rptr_d = rptr_q + PTR_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         if (push) mem_q[wptr_q[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/dvs_event_timestamper.sv
// rtl/dvs_event_timestamper.sv - range-checks DVS events, stamps them in microseconds and buffers them
module dvs_event_timestamper
   import dvs_ravens_pkg::*;
#(
   parameter int FIFO_DEPTH    = 8,
   parameter int CYCLES_PER_US = dvs_ravens_pkg::CYCLES_PER_US
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ts_clear,
   input  logic                       in_valid,
   input  logic [DVS_X_ADDR_BITS-1:0] in_x,
   input  logic [DVS_Y_ADDR_BITS-1:0] in_y,
   input  logic                       in_pol,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DVS_X_ADDR_BITS-1:0] out_x,
   output logic [DVS_Y_ADDR_BITS-1:0] out_y,
   output logic                       out_pol,
   output logic [TIMESTAMP_BITS-1:0]  out_ts,
   output logic [15:0]                drop_count,
   output logic [15:0]                range_err_count,
   output logic                       ts_wrap
);

   localparam int PW = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
   localparam logic [PW-1:0]             PRE_LAST = PW'(CYCLES_PER_US - 1);
   localparam logic [PW-1:0]             PRE_ONE  = PW'(1);
   localparam logic [TIMESTAMP_BITS-1:0] TS_ONE   = TIMESTAMP_BITS'(1);
   localparam logic [15:0]               CNT_ONE  = 16'd1;

   logic [PW-1:0]             pre_q, pre_d;
   logic [TIMESTAMP_BITS-1:0] ts_q, ts_d;
   logic                      wrap_q, wrap_d;
   logic [15:0]               drop_q, drop_d;
   logic [15:0]               rerr_q, rerr_d;

   logic      fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic      in_range;
   ts_event_t wr_evt, head;

   always_comb begin
      pre_d  = pre_q;
      ts_d   = ts_q;
      wrap_d = 1'b0;
      if (ts_clear) begin
         pre_d = '0;
         ts_d  = '0;
      end else if (pre_q == PRE_LAST) begin
         pre_d  = '0;
         ts_d   = ts_q + TS_ONE;
         wrap_d = &ts_q;
      end else begin
         pre_d = pre_q + PRE_ONE;
      end
   end

   // A push into a full FIFO is still accepted when the head leaves in the same cycle.
   assign in_range  = in_sensor(in_x, in_y);
   assign fifo_pop  = !fifo_empty && out_ready;
   assign fifo_push = in_valid && in_range && (!fifo_full || fifo_pop);

   always_comb begin
      drop_d = drop_q;
      rerr_d = rerr_q;
      if (in_valid && !in_range && (rerr_q != 16'hFFFF))
         rerr_d = rerr_q + CNT_ONE;
      if (in_valid && in_range && fifo_full && !fifo_pop && (drop_q != 16'hFFFF))
         drop_d = drop_q + CNT_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q  <= '0;
         ts_q   <= '0;
         wrap_q <= 1'b0;
         drop_q <= '0;
         rerr_q <= '0;
      end else begin
         pre_q  <= pre_d;
         ts_q   <= ts_d;
         wrap_q <= wrap_d;
         drop_q <= drop_d;
         rerr_q <= rerr_d;
      end
   end

   assign wr_evt.evt.x   = in_x;
   assign wr_evt.evt.y   = in_y;
   assign wr_evt.evt.pol = in_pol;
   assign wr_evt.ts      = ts_q;

   dvs_event_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .wdata (wr_evt),
      .full  (fifo_full),
      .pop   (fifo_pop),
      .empty (fifo_empty),
      .rdata (head)
   );

   assign out_valid       = !fifo_empty;
   assign out_x           = head.evt.x;
   assign out_y           = head.evt.y;
   assign out_pol         = head.evt.pol;
   assign out_ts          = head.ts;
   assign drop_count      = drop_q;
   assign range_err_count = rerr_q;
   assign ts_wrap         = wrap_q;

endmodule

// File: tb/tb_dvs_event_timestamper.sv
// tb/tb_dvs_event_timestamper.sv - randomized bench for dvs_event_timestamper against a queue model
module tb_dvs_event_timestamper;

   localparam int          DEPTH = 8;
   localparam int          CPU   = 100;
   localparam logic [47:0] MASK  = 48'hFFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst_n, ts_clear, in_valid, in_pol, out_ready;
   logic [8:0]  in_x, in_y;
   logic        out_valid, out_pol, ts_wrap;
   logic [8:0]  out_x, out_y;
   logic [47:0] out_ts;
   logic [15:0] drop_count, range_err_count;

   always #5 clk = ~clk;

   dvs_event_timestamper #(.FIFO_DEPTH(DEPTH), .CYCLES_PER_US(CPU)) dut (
      .clk(clk), .rst_n(rst_n), .ts_clear(ts_clear),
      .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .in_pol(in_pol),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .out_y(out_y), .out_pol(out_pol), .out_ts(out_ts),
      .drop_count(drop_count), .range_err_count(range_err_count), .ts_wrap(ts_wrap)
   );

   typedef struct {
      int          x;
      int          y;
      bit          pol;
      logic [47:0] ts;
   } ev_t;

   ev_t         mq[$];
   longint      m_cyc;
   logic [47:0] m_base;
   int          m_drop, m_rerr;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          wrap_seen = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [47:0] model_ts();
      return 48'(m_base + 48'(m_cyc / CPU));
   endfunction

   task automatic model_reset();
      mq.delete();
      m_cyc  = 0;
      m_base = '0;
      m_drop = 0;
      m_rerr = 0;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; in_x = '0; in_y = '0; in_pol = 1'b0; ts_clear = 1'b0;
   endtask

   task automatic rand_inputs(input int p_valid, input bit allow_clear);
      in_valid  = ($urandom_range(0, 99) < p_valid);
      in_x      = 9'($urandom_range(0, 359));
      in_y      = 9'($urandom_range(0, 269));
      in_pol    = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      ts_clear  = allow_clear && ($urandom_range(0, 99) == 0);
   endtask

   // Applies the current inputs for one cycle, advances the model, then compares just after the edge.
   task automatic step();
      logic [47:0] ts_now, ts_nxt;
      bit          pop, push, wrap_exp;
      ev_t         e;
      ts_now = model_ts();
      pop    = (mq.size() != 0) && out_ready;
      push   = 1'b0;
      if (in_valid) begin
         if (int'(in_x) >= 346 || int'(in_y) >= 260) begin
            if (m_rerr != 65535) m_rerr++;
         end else if (mq.size() == DEPTH && !pop) begin
            if (m_drop != 65535) m_drop++;
         end else begin
            push = 1'b1;
         end
      end
      e.x = int'(in_x); e.y = int'(in_y); e.pol = in_pol; e.ts = ts_now;
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(e);
      if (ts_clear) begin
         m_cyc  = 0;
         m_base = '0;
      end else begin
         m_cyc++;
      end
      ts_nxt   = model_ts();
      wrap_exp = !ts_clear && (ts_now == MASK) && (ts_nxt == '0);
      @(posedge clk);
      #1;
      if (ts_wrap) wrap_seen++;
      check_eq("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      check_eq("drop_count", 64'(drop_count), 64'(m_drop));
      check_eq("range_err_count", 64'(range_err_count), 64'(m_rerr));
      check_eq("ts_wrap", 64'(ts_wrap), 64'(wrap_exp));
      check_eq("timestamp", 64'(dut.ts_q), 64'(ts_nxt));
      if (mq.size() != 0) begin
         check_eq("out_x", 64'(out_x), 64'(mq[0].x));
         check_eq("out_y", 64'(out_y), 64'(mq[0].y));
         check_eq("out_pol", 64'(out_pol), 64'(mq[0].pol));
         check_eq("out_ts", 64'(out_ts), 64'(mq[0].ts));
      end
   endtask

   task automatic push_evt(input int x, input int y, input bit pol);
      in_valid = 1'b1; in_x = 9'(x); in_y = 9'(y); in_pol = pol;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      out_ready = 1'b1;
      idle_inputs();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_out_valid", 64'(out_valid), 0);
      check_eq("rst_out_ts", 64'(out_ts), 0);
      check_eq("rst_out_x", 64'(out_x), 0);
      check_eq("rst_drop", 64'(drop_count), 0);
      check_eq("rst_rerr", 64'(range_err_count), 0);
      check_eq("rst_wrap", 64'(ts_wrap), 0);
      rst_n = 1'b1;

      // First stamp lands in tick 1, then idle until 250 cycles.
      while (m_cyc < 150) step();
      push_evt(345, 259, 1'b1);
      check_eq("edge_evt_x", 64'(out_x), 345);
      check_eq("edge_evt_y", 64'(out_y), 259);
      check_eq("edge_evt_ts", 64'(out_ts), 1);
      while (m_cyc < 250) step();
      check_eq("ts_at_250", 64'(dut.ts_q), 2);
      check_eq("no_wrap_idle", 64'(wrap_seen), 0);

      push_evt(346, 0, 1'b0);
      push_evt(0, 260, 1'b1);
      check_eq("range_errs", 64'(range_err_count), 2);
      check_eq("range_no_drop", 64'(drop_count), 0);

      // Overfill with the sink stalled, then push and pop together while full.
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) push_evt(i * 30, i * 20, i[0]);
      check_eq("fill_drops", 64'(drop_count), 2);
      out_ready = 1'b1;
      push_evt(100, 100, 1'b1);
      check_eq("full_pushpop_drop", 64'(drop_count), 2);
      check_eq("full_pushpop_occ", 64'(mq.size()), DEPTH);
      out_ready = 1'b1;
      repeat (DEPTH + 2) step();

      for (int i = 0; i < 400; i++) begin
         rand_inputs(70, 1'b1);
         step();
      end
      idle_inputs();

      // Timestamp wrap: deposit the maximum three cycles before a tick.
      out_ready = 1'b1;
      while ((m_cyc % CPU) != 97) step();
      dut.ts_q = MASK;
      m_base   = 48'(MASK - 48'(m_cyc / CPU));
      wrap_seen = 0;
      for (int i = 0; i < 6; i++) push_evt(10 + i, 20, 1'b0);
      while ((m_cyc % CPU) != 50) step();
      check_eq("wrap_ts_zero", 64'(dut.ts_q), 0);
      check_eq("wrap_pulses", 64'(wrap_seen), 1);

      // Clear coinciding with an event at timestamp 7.
      ts_clear = 1'b1;
      step();
      ts_clear = 1'b0;
      while (m_cyc < 700) step();
      out_ready = 1'b0;
      ts_clear = 1'b1;
      push_evt(5, 6, 1'b1);
      ts_clear = 1'b0;
      check_eq("clear_evt_ts", 64'(out_ts), 7);
      check_eq("clear_ts_zero", 64'(dut.ts_q), 0);

      // Asynchronous reset in the middle of a burst.
      for (int i = 0; i < 12; i++) begin
         rand_inputs(90, 1'b0);
         out_ready = 1'b0;
         step();
      end
      idle_inputs();
      #3;
      rst_n = 1'b0;
      #1;
      check_eq("async_out_valid", 64'(out_valid), 0);
      check_eq("async_drop", 64'(drop_count), 0);
      check_eq("async_rerr", 64'(range_err_count), 0);
      check_eq("async_out_ts", 64'(out_ts), 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 400; i++) begin
         rand_inputs(85, 1'b1);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dvs_event_timestamper.md
# dvs_event_timestamper

Front-end stage between the DVS camera event decoder and the RAVENS event formatter. It accepts address events (x, y, polarity) that cannot be stalled and range-checks them against the sensor geometry. Each accepted event is tagged with a 48-bit free-running microsecond timestamp and buffered in a small FIFO. The FIFO drains to the downstream RAVENS stage over a valid/ready handshake.

## Interface
Parameters:
- FIFO_DEPTH, 8: event buffer entries; power of two, ≥2.
- CYCLES_PER_US, dvs_ravens_pkg::CYCLES_PER_US (100): clock cycles per timestamp tick.

Ports:
- clk  in  1  system clock; all logic rises on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ts_clear  in  1  synchronous clear of timestamp and prescaler.
- in_valid  in  1  event present this cycle; no backpressure to source.
- in_x  in  DVS_X_ADDR_BITS (9)  column address.
- in_y  in  DVS_Y_ADDR_BITS (9)  row address.
- in_pol  in  1  polarity, 1 = ON.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts head.
- out_x  out  9  head column.
- out_y  out  9  head row.
- out_pol  out  1  head polarity.
- out_ts  out  TIMESTAMP_BITS (48)  head timestamp, µs.
- drop_count  out  16  events lost to full FIFO; saturating.
- range_err_count  out  16  events with out-of-range coordinates; saturating.
- ts_wrap  out  1  one-cycle pulse when timestamp wraps to 0.

## Operation
- Reset values: all outputs 0; FIFO empty; prescaler = 0; timestamp = 0.
- Prescaler counts 0..CYCLES_PER_US-1.
  - When it equals CYCLES_PER_US-1, it returns to 0 and the timestamp increments by 1.
  - Timestamp wraps 2^48-1 → 0. ts_wrap is asserted the cycle the register holds 0 after the wrap.
- ts_clear: prescaler and timestamp are 0 on the next cycle. It has priority over increment and suppresses ts_wrap.
- Event classification, on cycles with in_valid = 1, in priority order:
  - in_x ≥ 346 or in_y ≥ 260: discarded; range_err_count += 1 (saturates at 0xFFFF).
  - FIFO full and no pop this cycle: discarded; drop_count += 1 (saturates).
  - Otherwise written as {x, y, pol, ts}, where ts is the timestamp register value in that same cycle (pre-clear/pre-increment).
- Pop occurs when out_valid && out_ready. Outputs present the FIFO head directly from registered storage.
- Push and pop in the same cycle are allowed at any occupancy, including full, where the push is not dropped. Occupancy is unchanged.
- FIFO order is strict; no reordering or coalescing.

## Timing
- Push at edge N → out_valid high after edge N (visible in cycle N+1) when the FIFO was empty. No combinational in→out path.
- Head fields remain stable while out_valid && !out_ready.
- Pop at edge N: the next entry is presented in cycle N+1; out_valid falls in N+1 if the FIFO becomes empty.
- Sustained throughput: 1 event/cycle in and out.
- Counters update at the edge ending the event's cycle.
- Asynchronous reset mid-operation: FIFO contents and counters are lost immediately; outputs go to reset values without waiting for a clock.
- Stamp resolution: an event is stamped with the tick in which it arrived; precision is ±1 µs relative to the sensor.

## Structure
- Add to dvs_ravens_pkg:
  - CYCLES_PER_US = 1000 / CLK_PERIOD_NS.
  - typedef dvs_event_t (x, y, pol) and ts_event_t (dvs_event_t + 48-bit ts).
  - Note: the existing CLK_PERIOD_US truncates to 0 and must not be used for tick generation.
- Sub-module dvs_event_fifo: synchronous FIFO of ts_event_t.
  - Parameter DEPTH.
  - Ports push/full/pop/empty.
  - Pointers carry one extra wrap bit for full/empty detection.
- Top holds the prescaler, timestamp register, range checker and counters.

## Test plan
- Reset, then idle for 250 cycles → timestamp = 2, ts_wrap never asserted, out_valid = 0.
- Event (x=345, y=259, pol=1) at cycle 150 after reset → out_valid in cycle 151 with out_x=345, out_y=259, out_pol=1, out_ts=1.
- Events x=346 and y=260 (one each) → no FIFO write, range_err_count = 2, drop_count = 0.
- Hold out_ready=0 and push 10 valid events with FIFO_DEPTH=8 → 8 buffered, drop_count = 2. Then push and pop in the same cycle while full → no drop, occupancy stays 8.
- Force the timestamp to 2^48-1 via hierarchical deposit and run 100 cycles → timestamp = 0, single-cycle ts_wrap pulse. An event stamped in the prior cycle carries out_ts = 2^48-1.
- Assert ts_clear in the same cycle as an event while timestamp = 7 → event out_ts = 7; timestamp = 0 on the next cycle. Then assert rst_n=0 mid-burst → out_valid drops immediately and counters read 0.
